// File: rtl/bcd_updown_counter.sv
// 4-digit BCD up/down counter driven by debounced button levels.
// A rising edge steps once; a held button auto-repeats after HOLD_CYCLES,
// then every RPT_CYCLES. clr_db clears the count and cancels any hold.
module bcd_updown_counter #(
  parameter int HOLD_CYCLES = 50_000_000,
  parameter int RPT_CYCLES  = 10_000_000,
  parameter int TMR_W       = 26
) (
  input  logic        clk_in,
  input  logic        reset,
  input  logic        up_db,
  input  logic        down_db,
  input  logic        clr_db,
  output logic [15:0] count_bcd,
  output logic        step,
  output logic        wrap,
  output logic        dir
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RPT  = 2'd2;

  localparam logic [TMR_W-1:0] HOLD_LAST = TMR_W'(HOLD_CYCLES - 1);
  localparam logic [TMR_W-1:0] RPT_LAST  = TMR_W'(RPT_CYCLES - 1);

  logic [1:0]       state, state_n;
  logic [TMR_W-1:0] timer, timer_n;
  logic             up_q, down_q;
  logic             rise_up, rise_dn;
  logic             req_up, req_dn, req_same;
  logic             do_step, step_up;
  logic [15:0]      count_n;
  logic             carry_out;

  assign rise_up  = up_db & ~up_q;
  assign rise_dn  = down_db & ~down_q;
  assign req_up   = ~clr_db & up_db & ~down_db;
  assign req_dn   = ~clr_db & down_db & ~up_db;
  // While holding, dir still reflects the direction the hold started with.
  assign req_same = dir ? req_up : req_dn;

  // Hold/repeat FSM: decides whether this cycle produces a step.
  always_comb begin
    state_n = state;
    timer_n = timer;
    do_step = 1'b0;
    step_up = dir;
    if (clr_db) begin
      state_n = S_IDLE;
      timer_n = '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (rise_up && req_up) begin
            do_step = 1'b1;
            step_up = 1'b1;
            timer_n = '0;
            state_n = S_WAIT;
          end else if (rise_dn && req_dn) begin
            do_step = 1'b1;
            step_up = 1'b0;
            timer_n = '0;
            state_n = S_WAIT;
          end
        end
        S_WAIT: begin
          if (!req_same) begin
            state_n = S_IDLE;
            timer_n = '0;
          end else if (timer == HOLD_LAST) begin
            do_step = 1'b1;
            timer_n = '0;
            state_n = S_RPT;
          end else begin
            timer_n = timer + TMR_W'(1);
          end
        end
        S_RPT: begin
          if (!req_same) begin
            state_n = S_IDLE;
            timer_n = '0;
          end else if (timer == RPT_LAST) begin
            do_step = 1'b1;
            timer_n = '0;
          end else begin
            timer_n = timer + TMR_W'(1);
          end
        end
        default: begin
          state_n = S_IDLE;
          timer_n = '0;
        end
      endcase
    end
  end

  // Per-digit BCD increment/decrement; carry out of the top digit means wrap.
  always_comb begin
    logic       c;
    logic [3:0] d;
    c       = 1'b1;
    count_n = count_bcd;
    for (int i = 0; i < 4; i++) begin
      d = count_bcd[i*4 +: 4];
      if (c) begin
        if (step_up) begin
          if (d == 4'd9) count_n[i*4 +: 4] = 4'd0;
          else begin
            count_n[i*4 +: 4] = d + 4'd1;
            c = 1'b0;
          end
        end else begin
          if (d == 4'd0) count_n[i*4 +: 4] = 4'd9;
          else begin
            count_n[i*4 +: 4] = d - 4'd1;
            c = 1'b0;
          end
        end
      end
    end
    carry_out = c;
  end

  // State, edge-detect history, count and step/wrap pulses.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      timer     <= '0;
      up_q      <= 1'b0;
      down_q    <= 1'b0;
      count_bcd <= 16'h0000;
      step      <= 1'b0;
      wrap      <= 1'b0;
      dir       <= 1'b1;
    end else begin
      state  <= state_n;
      timer  <= timer_n;
      up_q   <= up_db;
      down_q <= down_db;
      step   <= do_step;
      wrap   <= do_step & carry_out;
      if (clr_db) begin
        count_bcd <= 16'h0000;
      end else if (do_step) begin
        count_bcd <= count_n;
        dir       <= step_up;
      end
    end
  end

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Directed testbench for bcd_updown_counter with short hold/repeat timing.
module tb_bcd_updown_counter;

  logic        clk_in = 1'b0;
  logic        reset  = 1'b1;
  logic        up_db  = 1'b0;
  logic        down_db = 1'b0;
  logic        clr_db = 1'b0;
  logic [15:0] count_bcd;
  logic        step, wrap, dir;

  int n_cmp = 0;
  int n_bad = 0;
  int step_cnt = 0;
  int wrap_cnt = 0;

  bcd_updown_counter #(.HOLD_CYCLES(8), .RPT_CYCLES(4), .TMR_W(4)) dut (
    .clk_in(clk_in), .reset(reset), .up_db(up_db), .down_db(down_db),
    .clr_db(clr_db), .count_bcd(count_bcd), .step(step), .wrap(wrap), .dir(dir)
  );

  always #5 clk_in = ~clk_in;

  always @(negedge clk_in) begin
    if (step === 1'b1) step_cnt++;
    if (wrap === 1'b1) wrap_cnt++;
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic do_reset();
    up_db = 1'b0; down_db = 1'b0; clr_db = 1'b0;
    reset = 1'b1;
    #2;
    reset = 1'b0;
    tick();
  endtask

  task automatic press_up(input int n);
    up_db = 1'b1;
    repeat (n) tick();
    up_db = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    n_cmp++;
    if (count_bcd !== 16'h0000 || step !== 1'b0 || wrap !== 1'b0 || dir !== 1'b1) begin
      n_bad++;
      $display("FAIL reset: count=%h step=%b wrap=%b dir=%b, want 0000 0 0 1",
               count_bcd, step, wrap, dir);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_presses();
    int s0, w0;
    do_reset();
    s0 = step_cnt; w0 = wrap_cnt;
    repeat (3) press_up(3);
    n_cmp++;
    if (count_bcd !== 16'h0003 || dir !== 1'b1) begin
      n_bad++;
      $display("FAIL presses_count: count=%h dir=%b, want 0003 1", count_bcd, dir);
    end
    n_cmp++;
    if (step_cnt - s0 !== 3 || wrap_cnt - w0 !== 0) begin
      n_bad++;
      $display("FAIL presses_pulses: steps=%0d wraps=%0d, want 3 0",
               step_cnt - s0, wrap_cnt - w0);
    end
  endtask

  task automatic test_carry();
    do_reset();
    repeat (9) press_up(1);
    n_cmp++;
    if (count_bcd !== 16'h0009) begin
      n_bad++;
      $display("FAIL preload_9: count=%h, want 0009", count_bcd);
    end
    press_up(1);
    n_cmp++;
    if (count_bcd !== 16'h0010) begin
      n_bad++;
      $display("FAIL carry_10: count=%h, want 0010", count_bcd);
    end
    repeat (989) press_up(1);
    n_cmp++;
    if (count_bcd !== 16'h0999) begin
      n_bad++;
      $display("FAIL preload_999: count=%h, want 0999", count_bcd);
    end
    up_db = 1'b1;
    tick();
    n_cmp++;
    if (count_bcd !== 16'h1000 || step !== 1'b1 || wrap !== 1'b0) begin
      n_bad++;
      $display("FAIL carry_1000: count=%h step=%b wrap=%b, want 1000 1 0",
               count_bcd, step, wrap);
    end
    up_db = 1'b0;
    repeat (2) tick();
    down_db = 1'b1;
    tick();
    n_cmp++;
    if (count_bcd !== 16'h0999 || dir !== 1'b0 || wrap !== 1'b0) begin
      n_bad++;
      $display("FAIL borrow_999: count=%h dir=%b wrap=%b, want 0999 0 0",
               count_bcd, dir, wrap);
    end
    down_db = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_wrap();
    do_reset();
    down_db = 1'b1;
    tick();
    n_cmp++;
    if (count_bcd !== 16'h9999 || step !== 1'b1 || wrap !== 1'b1 || dir !== 1'b0) begin
      n_bad++;
      $display("FAIL wrap_down0: count=%h step=%b wrap=%b dir=%b, want 9999 1 1 0",
               count_bcd, step, wrap, dir);
    end
    down_db = 1'b0;
    repeat (2) tick();
    up_db = 1'b1;
    tick();
    n_cmp++;
    if (count_bcd !== 16'h0000 || step !== 1'b1 || wrap !== 1'b1 || dir !== 1'b1) begin
      n_bad++;
      $display("FAIL wrap_up: count=%h step=%b wrap=%b dir=%b, want 0000 1 1 1",
               count_bcd, step, wrap, dir);
    end
    up_db = 1'b0;
    tick();
    n_cmp++;
    if (step !== 1'b0 || wrap !== 1'b0) begin
      n_bad++;
      $display("FAIL wrap_pulse_len: step=%b wrap=%b, want 0 0", step, wrap);
    end
    tick();
    down_db = 1'b1;
    tick();
    n_cmp++;
    if (count_bcd !== 16'h9999 || wrap !== 1'b1 || dir !== 1'b0) begin
      n_bad++;
      $display("FAIL wrap_down: count=%h wrap=%b dir=%b, want 9999 1 0",
               count_bcd, wrap, dir);
    end
    down_db = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_hold_repeat();
    logic exp_step;
    do_reset();
    up_db = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (i == 20) up_db = 1'b0;
      exp_step = (i == 1 || i == 9 || i == 13 || i == 17);
      n_cmp++;
      if (step !== exp_step) begin
        n_bad++;
        $display("FAIL hold_step_c%0d: step=%b, want %b", i, step, exp_step);
      end
    end
    n_cmp++;
    if (count_bcd !== 16'h0004) begin
      n_bad++;
      $display("FAIL hold_count: count=%h, want 0004", count_bcd);
    end
    repeat (10) tick();
    n_cmp++;
    if (count_bcd !== 16'h0004) begin
      n_bad++;
      $display("FAIL hold_release: count=%h, want 0004", count_bcd);
    end
  endtask

  task automatic test_both_buttons();
    int s0;
    do_reset();
    up_db = 1'b1;
    repeat (3) tick();
    s0 = step_cnt;
    down_db = 1'b1;
    repeat (10) tick();
    n_cmp++;
    if (count_bcd !== 16'h0001 || step_cnt - s0 !== 0) begin
      n_bad++;
      $display("FAIL both_held: count=%h steps=%0d, want 0001 0", count_bcd, step_cnt - s0);
    end
    down_db = 1'b0;
    repeat (12) tick();
    n_cmp++;
    if (count_bcd !== 16'h0001 || step_cnt - s0 !== 0) begin
      n_bad++;
      $display("FAIL down_release: count=%h steps=%0d, want 0001 0", count_bcd, step_cnt - s0);
    end
    up_db = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_clear_and_async_reset();
    int s0;
    do_reset();
    repeat (41) press_up(1);
    up_db = 1'b1;
    repeat (3) tick();
    n_cmp++;
    if (count_bcd !== 16'h0042) begin
      n_bad++;
      $display("FAIL clr_preload: count=%h, want 0042", count_bcd);
    end
    clr_db = 1'b1;
    s0 = step_cnt;
    tick();
    n_cmp++;
    if (count_bcd !== 16'h0000 || step !== 1'b0) begin
      n_bad++;
      $display("FAIL clr: count=%h step=%b, want 0000 0", count_bcd, step);
    end
    tick();
    clr_db = 1'b0;
    repeat (12) tick();
    n_cmp++;
    if (count_bcd !== 16'h0000 || step_cnt - s0 !== 0) begin
      n_bad++;
      $display("FAIL clr_after: count=%h steps=%0d, want 0000 0", count_bcd, step_cnt - s0);
    end
    up_db = 1'b0;
    tick();
    down_db = 1'b1;
    repeat (10) tick();
    n_cmp++;
    if (count_bcd !== 16'h9998 || dir !== 1'b0) begin
      n_bad++;
      $display("FAIL rpt_preload: count=%h dir=%b, want 9998 0", count_bcd, dir);
    end
    #2 reset = 1'b1;
    #1;
    n_cmp++;
    if (count_bcd !== 16'h0000 || step !== 1'b0 || wrap !== 1'b0 || dir !== 1'b1) begin
      n_bad++;
      $display("FAIL async_reset: count=%h step=%b wrap=%b dir=%b, want 0000 0 0 1",
               count_bcd, step, wrap, dir);
    end
    #2 reset = 1'b0;
    tick();
    n_cmp++;
    if (count_bcd !== 16'h9999 || step !== 1'b1) begin
      n_bad++;
      $display("FAIL held_through_reset: count=%h step=%b, want 9999 1", count_bcd, step);
    end
    down_db = 1'b0;
    repeat (2) tick();
  endtask

  initial begin
    test_reset();
    test_presses();
    test_carry();
    test_wrap();
    test_hold_repeat();
    test_both_buttons();
    test_clear_and_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
